// File: rtl/sum_datapath.sv
// Register-file datapath for the summation processor: eight registers, adder,
// constant-1 source, <= LIMIT compare, registered output. Macro SUM_DATAPATH_SAT_ADD_EN selects saturating add.
module sum_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int LIMIT      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RFSrcMuxSel,
    input  logic [2:0]            readAddr1,
    input  logic [2:0]            readAddr2,
    input  logic [2:0]            writeAddr,
    input  logic                  writeEn,
    input  logic                  outBuf,
    output logic                  iLe10,
    output logic [DATA_WIDTH-1:0] outPort,
    output logic                  outValid,
    output logic                  ovf
);

    localparam logic [DATA_WIDTH-1:0] LIMIT_V = DATA_WIDTH'(LIMIT);
    localparam logic [DATA_WIDTH-1:0] ONE_V   = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs [8];
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic [DATA_WIDTH:0]   sum;
    logic                  carry;
    logic [DATA_WIDTH-1:0] add_result;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_active;

    // R0 is never written, so it stays at its reset value of zero.
    assign rdata1 = (readAddr1 == 3'd0) ? '0 : regs[readAddr1];
    assign rdata2 = (readAddr2 == 3'd0) ? '0 : regs[readAddr2];

    assign sum   = {1'b0, rdata1} + {1'b0, rdata2};
    assign carry = sum[DATA_WIDTH];

`ifdef SUM_DATAPATH_SAT_ADD_EN
    assign add_result = carry ? '1 : sum[DATA_WIDTH-1:0];
`else
    assign add_result = sum[DATA_WIDTH-1:0];
`endif

    assign wdata     = RFSrcMuxSel ? ONE_V : add_result;
    assign wr_active = writeEn && (writeAddr != 3'd0);
    assign iLe10     = (rdata1 <= LIMIT_V);

    // outBuf in cycle N loads outPort and raises outValid for cycle N+1 only;
    // there is no back-pressure, the consumer must take the value that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            outPort  <= '0;
            outValid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (wr_active) begin
                regs[writeAddr] <= wdata;
            end
            if (wr_active && !RFSrcMuxSel && carry) begin
                ovf <= 1'b1;
            end
            if (outBuf) begin
                outPort <= rdata1;
            end
            outValid <= outBuf;
        end
    end

endmodule

// File: tb/tb_sum_datapath.sv
// Directed self-checking bench for sum_datapath: reset, R0 behaviour, compare
// boundary, overflow, read-during-write on the output path, and a full program run.
module tb_sum_datapath;

    logic       clk;
    logic       reset;
    logic       RFSrcMuxSel;
    logic [2:0] readAddr1;
    logic [2:0] readAddr2;
    logic [2:0] writeAddr;
    logic       writeEn;
    logic       outBuf;
    logic       iLe10;
    logic [7:0] outPort;
    logic       outValid;
    logic       ovf;

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];

    sum_datapath #(.DATA_WIDTH(8), .LIMIT(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .RFSrcMuxSel (RFSrcMuxSel),
        .readAddr1   (readAddr1),
        .readAddr2   (readAddr2),
        .writeAddr   (writeAddr),
        .writeEn     (writeEn),
        .outBuf      (outBuf),
        .iLe10       (iLe10),
        .outPort     (outPort),
        .outValid    (outValid),
        .ovf         (ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        RFSrcMuxSel = 1'b0;
        readAddr1   = 3'd0;
        readAddr2   = 3'd0;
        writeAddr   = 3'd0;
        writeEn     = 1'b0;
        outBuf      = 1'b0;
    endtask

    task automatic do_write(input logic src, input logic [2:0] a1, input logic [2:0] a2,
                            input logic [2:0] wa);
        set_idle();
        RFSrcMuxSel = src;
        readAddr1   = a1;
        readAddr2   = a2;
        writeAddr   = wa;
        writeEn     = 1'b1;
        cycle();
        set_idle();
    endtask

    task automatic do_out(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        set_idle();
        readAddr1 = addr;
        outBuf    = 1'b1;
        cycle();
        set_idle();
        check({tag, "_port"}, outPort, exp);
        check({tag, "_valid"}, outValid, 1);
    endtask

    // Control-FSM program: 3 init cycles, then compare / R2+=R1 / R1+=R3 / output.
    task automatic run_program(input int n_cycles);
        int ph;
        int it;
        for (int c = 0; c < n_cycles; c++) begin
            set_idle();
            ph = -1;
            if (c == 0) begin
                writeAddr = 3'd1; writeEn = 1'b1;
            end else if (c == 1) begin
                writeAddr = 3'd2; writeEn = 1'b1;
            end else if (c == 2) begin
                RFSrcMuxSel = 1'b1; writeAddr = 3'd3; writeEn = 1'b1;
            end else begin
                ph = (c - 3) % 4;
                it = (c - 3) / 4;
                case (ph)
                    0: begin
                        readAddr1 = 3'd1;
                        #1;
                        check($sformatf("prog_cmp%0d", it), iLe10, 1);
                    end
                    1: begin
                        readAddr1 = 3'd2; readAddr2 = 3'd1; writeAddr = 3'd2; writeEn = 1'b1;
                    end
                    2: begin
                        readAddr1 = 3'd1; readAddr2 = 3'd3; writeAddr = 3'd1; writeEn = 1'b1;
                    end
                    default: begin
                        readAddr1 = 3'd2; outBuf = 1'b1;
                    end
                endcase
            end
            cycle();
            if (ph == 3) begin
                check($sformatf("prog_valid%0d", it), outValid, 1);
                if (exp_q.size() == 0) begin
                    check("prog_queue_empty", 1, 0);
                end else begin
                    check($sformatf("prog_out%0d", it), outPort, exp_q.pop_front());
                end
            end
        end
        set_idle();
    endtask

    task automatic fill_expected();
        logic [7:0] acc;
        exp_q.delete();
        acc = 8'd0;
        for (int k = 0; k <= 10; k++) begin
            acc = acc + 8'(k);
            exp_q.push_back(acc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        set_idle();
        reset = 1'b1;
        #12;
        check("rst_outPort", outPort, 0);
        check("rst_outValid", outValid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_iLe10", iLe10, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // R1 = R0 + R0, then output it
        do_write(1'b0, 3'd0, 3'd0, 3'd1);
        do_out("first_out", 3'd1, 8'd0);
        cycle();
        check("first_valid_drop", outValid, 0);
        check("first_ovf", ovf, 0);

        // R3 = 1, then count R1 up to 11 watching the compare boundary
        do_write(1'b1, 3'd0, 3'd0, 3'd3);
        for (int i = 1; i <= 11; i++) begin
            do_write(1'b0, 3'd1, 3'd3, 3'd1);
            readAddr1 = 3'd1;
            #1;
            check($sformatf("ile_r1_%0d", i), iLe10, (i <= 10) ? 1 : 0);
        end
        do_out("r1_eleven", 3'd1, 8'd11);

        // Write to R0 is dropped
        do_write(1'b1, 3'd0, 3'd0, 3'd0);
        do_out("r0_read", 3'd0, 8'd0);
        check("r0_ovf", ovf, 0);

        // R2 = 200, R4 = 100, then R5 = R2 + R4 overflows
        for (int i = 0; i < 200; i++) do_write(1'b0, 3'd2, 3'd3, 3'd2);
        for (int i = 0; i < 100; i++) do_write(1'b0, 3'd4, 3'd3, 3'd4);
        do_out("r2_200", 3'd2, 8'd200);
        do_out("r4_100", 3'd4, 8'd100);
        check("pre_ovf", ovf, 0);
        do_write(1'b0, 3'd2, 3'd4, 3'd5);
        check("ovf_set", ovf, 1);
`ifdef SUM_DATAPATH_SAT_ADD_EN
        do_out("r5_sum", 3'd5, 8'd255);
`else
        do_out("r5_sum", 3'd5, 8'd44);
`endif
        cycle();
        cycle();
        check("ovf_sticky", ovf, 1);

        // Same-cycle R2 <= R2+R1 and outBuf on R2: old value, then new value
        set_idle();
        readAddr1 = 3'd2; readAddr2 = 3'd1; writeAddr = 3'd2; writeEn = 1'b1; outBuf = 1'b1;
        cycle();
        check("rdw_old", outPort, 200);
        set_idle();
        readAddr1 = 3'd2; outBuf = 1'b1;
        cycle();
        set_idle();
        check("rdw_new", outPort, 211);
        check("b2b_valid", outValid, 1);

        // Program run interrupted by an asynchronous reset, then a full rerun
        fill_expected();
        run_program(20);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_outPort", outPort, 0);
        check("midrst_outValid", outValid, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_iLe10", iLe10, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fill_expected();
        run_program(47);
        check("prog_all_out", exp_q.size(), 0);
        check("prog_final", outPort, 8'h37);
        readAddr1 = 3'd1;
        #1;
        check("prog_exit_cmp", iLe10, 0);
        cycle();
        cycle();
        check("prog_hold", outPort, 8'h37);
        check("prog_valid_low", outValid, 0);
        check("prog_ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
